// File: rtl/traffic_timer.sv
// Per-light seconds countdown for the traffic light FSM: loads the duration picked by the
// one-hot selector, counts it down through a clock prescaler and decodes the handover flags.
module traffic_timer #(
    parameter int LIGHT_STATE_WIDTH = 3,
    parameter int CLK_PER_SEC       = 1000,
    parameter int CNT_WIDTH         = 7,
    parameter int GREEN_TIME        = 30,
    parameter int YELLOW_TIME       = 3,
    parameter int RED_TIME          = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
    output logic                         light_cnt_last,
    output logic                         second_cnt_pre_last,
    output logic                         sec_tick,
    output logic [CNT_WIDTH-1:0]         remaining_sec,
    output logic [3:0]                   sec_tens,
    output logic [3:0]                   sec_ones
);

    localparam int SEC_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_PRE  = SEC_W'(CLK_PER_SEC - 2);

    logic [SEC_W-1:0]             sec_cnt_reg, sec_cnt_next;
    logic [CNT_WIDTH-1:0]         light_cnt_reg, light_cnt_next;
    logic [LIGHT_STATE_WIDTH-1:0] init_q_reg, init_q_next;

    logic                 sel_valid;
    logic [CNT_WIDTH-1:0] sel_dur;
    logic [CNT_WIDTH-1:0] dur_masked [LIGHT_STATE_WIDTH];

    assign sel_valid = $onehot(light_cnt_init);

    // Each selector bit contributes its own duration; bits beyond red carry none.
    genvar gi;
    generate
        for (gi = 0; gi < LIGHT_STATE_WIDTH; gi++) begin : g_dur
            localparam logic [CNT_WIDTH-1:0] DUR =
                (gi == 0) ? CNT_WIDTH'(GREEN_TIME)  :
                (gi == 1) ? CNT_WIDTH'(YELLOW_TIME) :
                (gi == 2) ? CNT_WIDTH'(RED_TIME)    : CNT_WIDTH'(0);
            assign dur_masked[gi] = light_cnt_init[gi] ? DUR : CNT_WIDTH'(0);
        end
    endgenerate

    always_comb begin
        sel_dur = '0;
        for (int i = 0; i < LIGHT_STATE_WIDTH; i++) begin
            sel_dur = sel_dur | dur_masked[i];
        end
    end

    always_comb begin
        sec_cnt_next   = sec_cnt_reg;
        light_cnt_next = light_cnt_reg;
        init_q_next    = init_q_reg;
        if (!en) begin
            sec_cnt_next   = '0;
            light_cnt_next = '0;
            init_q_next    = '0;
        end else if (!sel_valid) begin
            sec_cnt_next   = '0;
            light_cnt_next = '0;
            init_q_next    = light_cnt_init;
        end else if (light_cnt_init != init_q_reg) begin
            // A new selector wins over any second wrap happening this cycle.
            sec_cnt_next   = '0;
            light_cnt_next = sel_dur;
            init_q_next    = light_cnt_init;
        end else if (sec_cnt_reg == SEC_LAST) begin
            sec_cnt_next = '0;
            if (light_cnt_reg > CNT_WIDTH'(1)) begin
                light_cnt_next = light_cnt_reg - CNT_WIDTH'(1);
            end else if (light_cnt_reg == CNT_WIDTH'(1)) begin
                // FSM did not advance: restart the phase instead of reaching zero.
                light_cnt_next = sel_dur;
            end
        end else begin
            sec_cnt_next = sec_cnt_reg + SEC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt_reg   <= '0;
            light_cnt_reg <= '0;
            init_q_reg    <= '0;
        end else begin
            sec_cnt_reg   <= sec_cnt_next;
            light_cnt_reg <= light_cnt_next;
            init_q_reg    <= init_q_next;
        end
    end

    assign light_cnt_last      = sel_valid && (light_cnt_reg == CNT_WIDTH'(1));
    assign second_cnt_pre_last = sel_valid && (sec_cnt_reg == SEC_PRE);
    assign sec_tick            = sel_valid && (sec_cnt_reg == SEC_LAST);
    assign remaining_sec       = light_cnt_reg;
    assign sec_tens            = 4'(light_cnt_reg / CNT_WIDTH'(10));
    assign sec_ones            = 4'(light_cnt_reg % CNT_WIDTH'(10));

endmodule
